lsu_mem_bridge: RTL and testbench

- Load/store unit between the multicycle core's data path and the word-organised unified memory.
- Accepts one byte, halfword or word access at a time from the core, using RISC-V funct3 encoding.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- SB/SH: performs a read-modify-write of the containing word.
- Flags misaligned and illegal accesses; times out a memory that never acknowledges.

---
 rtl/lsu_mem_bridge.sv | 171 +++++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the core data path and word-organised memory.
// Sub-word stores are done as a read-modify-write of the containing word.
module lsu_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misaligned,
   output logic        rsp_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_READ      = 3'd1;
   localparam logic [2:0] ST_RMW_READ  = 3'd2;
   localparam logic [2:0] ST_RMW_WRITE = 3'd3;
   localparam logic [2:0] ST_WRITE     = 3'd4;
   localparam logic [2:0] ST_RESP      = 3'd5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // The phase faults on the cycle the no-ack count would reach TIMEOUT_CYCLES.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic [2:0]  op_funct3;
   logic [1:0]  op_lane;
   logic [15:0] op_wdata;
   logic [15:0] wait_cnt;
   logic        req_illegal;
   logic        req_misaligned;

   function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (f3)
         F3_B:    extract_load = {{24{b[7]}}, b};
         F3_BU:   extract_load = {24'd0, b};
         F3_H:    extract_load = {{16{h[15]}}, h};
         F3_HU:   extract_load = {16'd0, h};
         default: extract_load = word;
      endcase
   endfunction

   function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [15:0] wd,
                                               input logic [31:0] word);
      logic [31:0] merged;
      merged = word;
      if (f3 == F3_H)
         merged[{lane[1], 4'b0000} +: 16] = wd;
      else
         merged[{lane, 3'b000} +: 8] = wd[7:0];
      merge_store = merged;
   endfunction

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign mem_req   = (state == ST_READ) || (state == ST_RMW_READ) ||
                      (state == ST_WRITE) || (state == ST_RMW_WRITE);
   assign mem_we    = (state == ST_WRITE) || (state == ST_RMW_WRITE);

   // Unsigned loads are legal, unsigned stores are not.
   always_comb begin
      req_illegal = 1'b1;
      case (req_funct3)
         F3_B, F3_H, F3_W: req_illegal = 1'b0;
         F3_BU, F3_HU:     req_illegal = req_we;
         default:          req_illegal = 1'b1;
      endcase
      req_misaligned = 1'b0;
      case (req_funct3)
         F3_H, F3_HU: req_misaligned = req_addr[0];
         F3_W:        req_misaligned = |req_addr[1:0];
         default:     req_misaligned = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         op_funct3      <= 3'd0;
         op_lane        <= 2'd0;
         op_wdata       <= 16'd0;
         wait_cnt       <= 16'd0;
         rsp_rdata      <= 32'd0;
         rsp_misaligned <= 1'b0;
         rsp_fault      <= 1'b0;
         mem_addr       <= 32'd0;
         mem_wdata      <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_funct3 <= req_funct3;
                  op_lane   <= req_addr[1:0];
                  op_wdata  <= req_wdata[15:0];
                  mem_addr  <= {req_addr[31:2], 2'b00};
                  mem_wdata <= req_wdata;
                  wait_cnt  <= 16'd0;
                  if (req_illegal) begin
                     state          <= ST_RESP;
                     rsp_fault      <= 1'b1;
                     rsp_misaligned <= 1'b0;
                     rsp_rdata      <= 32'd0;
                  end else if (req_misaligned) begin
                     state          <= ST_RESP;
                     rsp_fault      <= 1'b0;
                     rsp_misaligned <= 1'b1;
                     rsp_rdata      <= 32'd0;
                  end else if (!req_we) begin
                     state <= ST_READ;
                  end else if (req_funct3 == F3_W) begin
                     state <= ST_WRITE;
                  end else begin
                     state <= ST_RMW_READ;
                  end
               end
            end
            // All four memory phases share the ack/timeout handling.
            ST_READ, ST_RMW_READ, ST_WRITE, ST_RMW_WRITE: begin
               if (mem_ack) begin
                  wait_cnt <= 16'd0;
                  if (state == ST_RMW_READ) begin
                     mem_wdata <= merge_store(op_funct3, op_lane, op_wdata, mem_rdata);
                     state     <= ST_RMW_WRITE;
                  end else begin
                     state          <= ST_RESP;
                     rsp_fault      <= 1'b0;
                     rsp_misaligned <= 1'b0;
                     rsp_rdata      <= (state == ST_READ) ?
                                       extract_load(op_funct3, op_lane, mem_rdata) : 32'd0;
                  end
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  state          <= ST_RESP;
                  rsp_fault      <= 1'b1;
                  rsp_misaligned <= 1'b0;
                  rsp_rdata      <= 32'd0;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Randomised bench for lsu_mem_bridge against a transaction-level model
// with a delay-programmable memory responder.
module tb_lsu_mem_bridge;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;
   logic        rsp_fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ack = 1'b0;

   always #5 clk = ~clk;

   lsu_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misaligned(rsp_misaligned), .rsp_fault(rsp_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   int checks = 0;
   int fails  = 0;

   logic [31:0] model_mem [16];

   int          delay_rd = 0;
   int          delay_wr = 0;
   logic [31:0] exp_word_addr = 32'd0;

   int          phase_cnt = 0;
   logic [1:0]  prev_phase = 2'b00;
   logic [31:0] phase_addr = 32'd0;
   logic [31:0] phase_wdata = 32'd0;
   int          rd_acks = 0;
   int          wr_acks = 0;
   int          we_cycles = 0;
   int          stable_errs = 0;
   int          addr_errs = 0;
   int          rsp_pulses = 0;
   logic [31:0] last_wr_data = 32'd0;
   logic [31:0] last_rdata;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory responder and bus monitor; each phase acks after its programmed delay.
   always @(negedge clk) begin
      if (rsp_valid) rsp_pulses++;
      if (!mem_req) begin
         mem_ack   = 1'b0;
         phase_cnt = 0;
         mem_rdata = $urandom;
      end else begin
         if ({mem_req, mem_we} != prev_phase) begin
            phase_cnt   = 0;
            phase_addr  = mem_addr;
            phase_wdata = mem_wdata;
         end else if (mem_addr !== phase_addr || mem_wdata !== phase_wdata) begin
            stable_errs++;
         end
         if (mem_addr !== exp_word_addr) addr_errs++;
         if (mem_we) we_cycles++;
         mem_ack   = (phase_cnt == (mem_we ? delay_wr : delay_rd));
         mem_rdata = $urandom;
         if (mem_ack) begin
            if (mem_we) begin
               wr_acks++;
               last_wr_data = mem_wdata;
            end else begin
               rd_acks++;
               mem_rdata = model_mem[mem_addr[5:2]];
            end
         end
         phase_cnt++;
      end
      prev_phase = {mem_req, mem_we};
   end

   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int drd, input int dwr,
                                input string tag);
      bit          illegal, mis, fault, we_seen;
      int          size, off, lat, exp_lat, rd_exp, wr_exp;
      int          rd0, wr0, we0, st0, ad0;
      logic [31:0] old, v, mask, exp_wr, exp_rdata, junk;
      logic        o_mis, o_fault;

      illegal = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                  (!we && (f3 == 3'd4 || f3 == 3'd5)));
      size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off     = int'(addr % 4);
      mis     = !illegal && (off % size != 0);
      old     = model_mem[addr[5:2]];
      fault = 0; we_seen = 0; rd_exp = 0; wr_exp = 0; exp_rdata = 0; exp_wr = 0; exp_lat = 1;
      if (illegal) begin
         fault = 1;
      end else if (mis) begin
         exp_lat = 1;
      end else if (!we) begin
         if (drd >= T) begin
            fault = 1; exp_lat = T + 1;
         end else begin
            rd_exp = 1; exp_lat = 2 + drd;
            v = old >> (8 * off);
            if (size == 1) begin
               v = v & 32'hFF;
               if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end else if (size == 2) begin
               v = v & 32'hFFFF;
               if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            end
            exp_rdata = v;
         end
      end else if (size == 4) begin
         we_seen = 1;
         if (dwr >= T) begin
            fault = 1; exp_lat = T + 1;
         end else begin
            wr_exp = 1; exp_wr = wdata; exp_lat = 2 + dwr;
         end
      end else begin
         if (drd >= T) begin
            fault = 1; exp_lat = T + 1;
         end else begin
            rd_exp  = 1;
            we_seen = 1;
            mask    = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
            exp_wr  = (old & ~mask) | ((wdata << (8 * off)) & mask);
            if (dwr >= T) begin
               fault = 1; exp_lat = drd + 2 + T;
            end else begin
               wr_exp = 1; exp_lat = 3 + drd + dwr;
            end
         end
      end

      @(negedge clk);
      checkOutput({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
      delay_rd = drd; delay_wr = dwr;
      exp_word_addr = {addr[31:2], 2'b00};
      rd0 = rd_acks; wr0 = wr_acks; we0 = we_cycles; st0 = stable_errs; ad0 = addr_errs;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c;
            break;
         end
         junk = $urandom;
         req_valid = junk[0]; req_we = junk[1]; req_funct3 = junk[4:2];
         req_addr = $urandom; req_wdata = $urandom;
      end
      req_valid = 1'b0;
      last_rdata = rsp_rdata;
      o_mis = rsp_misaligned;
      o_fault = rsp_fault;
      checkOutput({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "/rdata"}, last_rdata, exp_rdata);
      checkOutput({tag, "/misaligned"}, {31'd0, o_mis}, {31'd0, mis});
      checkOutput({tag, "/fault"}, {31'd0, o_fault}, {31'd0, fault});
      checkOutput({tag, "/read_acks"}, 32'(rd_acks - rd0), 32'(rd_exp));
      checkOutput({tag, "/write_acks"}, 32'(wr_acks - wr0), 32'(wr_exp));
      checkOutput({tag, "/we_seen"}, {31'd0, (we_cycles - we0) > 0}, {31'd0, we_seen});
      checkOutput({tag, "/stable"}, 32'(stable_errs - st0), 32'd0);
      checkOutput({tag, "/mem_addr"}, 32'(addr_errs - ad0), 32'd0);
      if (wr_exp == 1) checkOutput({tag, "/wdata"}, last_wr_data, exp_wr);
      @(negedge clk);
      checkOutput({tag, "/pulse"}, {31'd0, rsp_valid}, 32'd0);
      checkOutput({tag, "/idle"}, {31'd0, req_ready}, 32'd1);
      checkOutput({tag, "/hold"}, rsp_rdata, last_rdata);
      if (wr_exp == 1) model_mem[addr[5:2]] = exp_wr;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int p0;
      logic [31:0] r, a, w;
      int drd, dwr;

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      for (int i = 0; i < 16; i++) model_mem[i] = $urandom;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset/req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("reset/rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("reset/mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("reset/mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("reset/flags", {30'd0, rsp_misaligned, rsp_fault}, 32'd0);
      checkOutput("reset/rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("reset/mem_addr", mem_addr, 32'd0);
      checkOutput("reset/mem_wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      model_mem[0] = 32'h8070_F1FF;
      applyStimulus(1'b0, 3'b000, 32'h41, 32'h0, 0, 0, "LB41");
      checkOutput("LB41/literal", last_rdata, 32'hFFFF_FFF1);
      applyStimulus(1'b0, 3'b100, 32'h41, 32'h0, 0, 0, "LBU41");
      checkOutput("LBU41/literal", last_rdata, 32'h0000_00F1);
      applyStimulus(1'b0, 3'b001, 32'h42, 32'h0, 0, 0, "LH42");
      checkOutput("LH42/literal", last_rdata, 32'hFFFF_8070);
      applyStimulus(1'b0, 3'b101, 32'h42, 32'h0, 0, 0, "LHU42");
      checkOutput("LHU42/literal", last_rdata, 32'h0000_8070);

      model_mem[0] = 32'h1122_3344;
      applyStimulus(1'b1, 3'b000, 32'h43, 32'h0000_00AB, 0, 0, "SB43");
      checkOutput("SB43/literal", last_wr_data, 32'hAB22_3344);
      applyStimulus(1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, 0, 3, "SW44");
      applyStimulus(1'b0, 3'b010, 32'h46, 32'h0, 0, 0, "LW46");
      applyStimulus(1'b1, 3'b001, 32'h45, 32'h1234, 0, 0, "SH45");
      applyStimulus(1'b0, 3'b011, 32'h40, 32'h0, 0, 0, "F3_011");
      applyStimulus(1'b1, 3'b100, 32'h40, 32'h0, 0, 0, "SBU");
      applyStimulus(1'b1, 3'b000, 32'h48, 32'h55, 9, 0, "SB_timeout");
      applyStimulus(1'b0, 3'b010, 32'h48, 32'h0, 3, 0, "LW_after_to");
      applyStimulus(1'b1, 3'b001, 32'h4E, 32'hBEEF, 1, 6, "SH_wr_timeout");

      // Abandon an RMW in its write phase with a synchronous reset.
      @(negedge clk);
      delay_rd = 0; delay_wr = 50; exp_word_addr = 32'h48;
      p0 = rsp_pulses;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4A; req_wdata = 32'h77;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_we) break;
      end
      checkOutput("rst/in_write", {31'd0, mem_we}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst/mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("rst/req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("rst/rsp_rdata", rsp_rdata, 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("rst/no_rsp", 32'(rsp_pulses - p0), 32'd0);
      applyStimulus(1'b0, 3'b010, 32'h48, 32'h0, 0, 0, "LW_after_rst");

      for (int n = 0; n < 300; n++) begin
         r = $urandom;
         a = $urandom;
         w = $urandom;
         drd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         dwr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         applyStimulus(r[0], r[3:1], a, w, drd, dwr, $sformatf("rnd%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
